// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder
// Turns the SPI receiver's word stream into framed commands: config RAM
// writes and reads, plus sample bursts forwarded to the filter input.
// Every output is registered. ram_en, x_valid and rsp_valid are single-cycle strobes.
module spi_cmd_decoder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] word_in,
    input  logic              word_valid,
    input  logic              frame_end,
    output logic [DATA_W-1:0] x_out,
    output logic              x_valid,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_valid,
    output logic [ERR_W-1:0]  err_count,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_DATA = 2'd1,
        RD_WAIT = 2'd2,
        BURST   = 2'd3
    } state_t;

    localparam logic [1:0] OP_WR    = 2'b00;
    localparam logic [1:0] OP_RD    = 2'b01;
    localparam logic [1:0] OP_BURST = 2'b10;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    // Holds up to 256 because a header count of 0 means 256 words.
    logic [8:0]        cnt, cnt_nxt;
    // RD_WAIT phase: 0 while the RAM access is in flight, 1 when ram_dout is valid.
    logic              rd_phase, rd_phase_nxt;
    logic              err_inc, do_wr, do_rd, do_x, do_rsp;

    // Header fields. Bits [12:8] carry no meaning, and the upper half of ram_dout is never returned.
    logic [1:0] hdr_op;
    logic [7:0] hdr_arg;
    logic       unused_bits;
    assign hdr_op      = word_in[14:13];
    assign hdr_arg     = word_in[7:0];
    assign unused_bits = &{1'b0, word_in[12:8], ram_dout[31:16]};

    // Next-state decode. The word is processed first, then frame_end is applied to the resulting state.
    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr_q;
        cnt_nxt      = cnt;
        rd_phase_nxt = rd_phase;
        err_inc      = 1'b0;
        do_wr        = 1'b0;
        do_rd        = 1'b0;
        do_x         = 1'b0;
        do_rsp       = 1'b0;
        case (state)
            IDLE: begin
                if (word_valid) begin
                    if (!word_in[15]) begin
                        err_inc = 1'b1;
                    end else begin
                        case (hdr_op)
                            OP_WR: begin
                                state_nxt = WR_DATA;
                                addr_nxt  = ADDR_W'(hdr_arg);
                            end
                            OP_RD: begin
                                state_nxt    = RD_WAIT;
                                addr_nxt     = ADDR_W'(hdr_arg);
                                rd_phase_nxt = 1'b0;
                                do_rd        = 1'b1;
                            end
                            OP_BURST: begin
                                state_nxt = BURST;
                                cnt_nxt   = (hdr_arg == 8'd0) ? 9'd256 : {1'b0, hdr_arg};
                            end
                            default: err_inc = 1'b1;
                        endcase
                    end
                end
            end
            WR_DATA: begin
                if (word_valid) begin
                    do_wr     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            RD_WAIT: begin
                // A word that arrives while a readback is pending has nowhere to go.
                if (word_valid) err_inc = 1'b1;
                if (!rd_phase) begin
                    rd_phase_nxt = 1'b1;
                end else begin
                    do_rsp    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            BURST: begin
                if (word_valid) begin
                    do_x    = 1'b1;
                    cnt_nxt = cnt - 9'd1;
                    if (cnt == 9'd1) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A closed frame aborts an unfinished write or burst. A readback runs to completion.
        if (frame_end && (state_nxt == WR_DATA || state_nxt == BURST)) begin
            state_nxt = IDLE;
            err_inc   = 1'b1;
        end
    end

    // State, registered outputs and the saturating error counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= '0;
            cnt       <= '0;
            rd_phase  <= 1'b0;
            x_out     <= '0;
            x_valid   <= 1'b0;
            ram_en    <= 1'b0;
            ram_we    <= 4'b0000;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_data  <= '0;
            rsp_valid <= 1'b0;
            err_count <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            addr_q    <= addr_nxt;
            cnt       <= cnt_nxt;
            rd_phase  <= rd_phase_nxt;
            busy      <= (state_nxt != IDLE);
            x_valid   <= do_x;
            rsp_valid <= do_rsp;
            ram_en    <= do_wr | do_rd;
            ram_we    <= do_wr ? 4'b0011 : 4'b0000;
            if (do_x) x_out <= word_in;
            if (do_rsp) rsp_data <= ram_dout[DATA_W-1:0];
            if (do_wr) begin
                ram_addr <= addr_q;
                ram_din  <= {{(32-DATA_W){1'b0}}, word_in};
            end else if (do_rd) begin
                ram_addr <= addr_nxt;
            end
            if (err_inc && (err_count != {ERR_W{1'b1}})) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// tb_spi_cmd_decoder
// Scoreboard bench: expected RAM accesses, samples and readbacks are queued
// as stimulus is driven and popped by a negedge monitor as the DUT emits them.
module tb_spi_cmd_decoder;

    typedef struct {
        logic [3:0]  we;
        logic [7:0]  addr;
        logic [31:0] din;
    } ram_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] word_in;
    logic        word_valid;
    logic        frame_end;
    logic [15:0] x_out;
    logic        x_valid;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;
    logic [15:0] rsp_data;
    logic        rsp_valid;
    logic [7:0]  err_count;
    logic        busy;

    logic [31:0] mem [0:255];
    ram_exp_t    ram_q[$];
    logic [15:0] x_q[$];
    logic [15:0] rsp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          rd_hdr_cyc = 0;
    int          exp_err = 0;

    spi_cmd_decoder #(.DATA_W(16), .ADDR_W(8), .ERR_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .word_in(word_in), .word_valid(word_valid),
        .frame_end(frame_end), .x_out(x_out), .x_valid(x_valid), .ram_en(ram_en),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .err_count(err_count), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Config RAM model: one-cycle read latency, byte write enables.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'b0000) ram_dout <= mem[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_din[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
        end
    endtask

    // Monitor: every strobe must match the head of its queue.
    always @(negedge clk) begin
        ram_exp_t e;
        if (reset_n) begin
            if (ram_en) begin
                if (ram_q.size() == 0) chk("ram_unexpected", 1, 0);
                else begin
                    e = ram_q.pop_front();
                    chk("ram_we", ram_we, e.we);
                    chk("ram_addr", ram_addr, e.addr);
                    if (e.we != 4'b0000) chk("ram_din", ram_din, e.din);
                end
            end
            if (x_valid) begin
                if (x_q.size() == 0) chk("x_unexpected", 1, 0);
                else chk("x_out", x_out, x_q.pop_front());
            end
            if (rsp_valid) begin
                if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    chk("rsp_data", rsp_data, rsp_q.pop_front());
                    chk("rsp_latency", cyc - rd_hdr_cyc, 2);
                end
            end
        end
    end

    // One word strobe; returns just after the edge that samples it.
    task automatic send(input logic [15:0] w, input logic fe);
        @(posedge clk); #1;
        word_in = w; word_valid = 1'b1; frame_end = fe;
        @(posedge clk); #1;
        word_valid = 1'b0; frame_end = 1'b0;
    endtask

    task automatic send_fe();
        @(posedge clk); #1;
        frame_end = 1'b1;
        @(posedge clk); #1;
        frame_end = 1'b0;
    endtask

    // Bounded wait for all expected traffic, then confirm nothing is left and check state.
    task automatic drain(input string tag);
        for (int i = 0; i < 30 && (ram_q.size() + x_q.size() + rsp_q.size()) > 0; i++)
            @(posedge clk);
        @(negedge clk);
        chk({tag, "_pending"}, ram_q.size() + x_q.size() + rsp_q.size(), 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_err"}, err_count, exp_err);
    endtask

    function automatic ram_exp_t mk(input logic [3:0] we, input logic [7:0] a, input logic [31:0] d);
        ram_exp_t r;
        r.we = we; r.addr = a; r.din = d;
        return r;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h0000_0001;
        reset_n = 1'b0; word_in = '0; word_valid = 1'b0; frame_end = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_x", {x_valid, x_out}, 0);
        chk("rst_ram", {ram_en, ram_we, ram_addr, ram_din}, 0);
        chk("rst_rsp", {rsp_valid, rsp_data}, 0);
        chk("rst_err_busy", {err_count, busy}, 0);
        @(negedge clk); reset_n = 1'b1;

        // Write alpha
        send(16'h8000, 1'b0);
        chk("wr_busy", busy, 1);
        ram_q.push_back(mk(4'b0011, 8'd0, 32'h0000_4000));
        send(16'h4000, 1'b0);
        drain("wr");
        chk("wr_mem", mem[0], 32'h0000_4000);

        // Readback of enable register
        ram_q.push_back(mk(4'b0000, 8'd1, 32'h0));
        rsp_q.push_back(16'h0001);
        send(16'hA001, 1'b0);
        rd_hdr_cyc = cyc;
        drain("rd");

        // Three-word burst
        send(16'hC003, 1'b0);
        foreach (x_q[i]) ;
        x_q.push_back(16'd10); send(16'd10, 1'b0);
        x_q.push_back(16'd20); send(16'd20, 1'b0);
        x_q.push_back(16'd30); send(16'd30, 1'b0);
        drain("burst");

        // Burst aborted by frame_end, then a new header must be accepted
        send(16'hC005, 1'b0);
        x_q.push_back(16'h0101); send(16'h0101, 1'b0);
        x_q.push_back(16'h0202); send(16'h0202, 1'b0);
        send_fe();
        exp_err = 1;
        drain("abort");
        send(16'h8002, 1'b0);
        ram_q.push_back(mk(4'b0011, 8'd2, 32'h0000_1234));
        send(16'h1234, 1'b0);
        drain("post_abort");

        // Reserved opcode
        send(16'hE000, 1'b0);
        exp_err = 2;
        drain("reserved");

        // Word during readback is dropped with an error; readback still completes
        ram_q.push_back(mk(4'b0000, 8'd0, 32'h0));
        rsp_q.push_back(16'h4000);
        send(16'hA000, 1'b0);
        rd_hdr_cyc = cyc;
        send(16'h0055, 1'b0);
        exp_err = 3;
        drain("rd_extra");

        // frame_end in IDLE has no effect; write data + frame_end still writes
        send_fe();
        send(16'h8003, 1'b0);
        ram_q.push_back(mk(4'b0011, 8'd3, 32'h0000_00AB));
        send(16'h00AB, 1'b1);
        drain("wr_fe");

        // Last burst word + frame_end is a clean finish
        send(16'hC002, 1'b0);
        x_q.push_back(16'h0AAA); send(16'h0AAA, 1'b0);
        x_q.push_back(16'h0BBB); send(16'h0BBB, 1'b1);
        drain("burst_fe");

        // Count 0 means 256 words
        send(16'hC000, 1'b0);
        for (int i = 0; i < 255; i++) begin
            x_q.push_back(16'(i)); send(16'(i), 1'b0);
        end
        chk("b256_busy_mid", busy, 1);
        x_q.push_back(16'h7FFF); send(16'h7FFF, 1'b0);
        drain("b256");

        // Error counter saturates
        for (int i = 0; i < 300; i++) send(16'(i) & 16'h7FFF, 1'b0);
        exp_err = 255;
        drain("sat");

        // Reset in the middle of a burst
        send(16'hC004, 1'b0);
        x_q.push_back(16'h0042); send(16'h0042, 1'b0);
        @(negedge clk); #1;
        reset_n = 1'b0;
        #2;
        chk("mid_rst_outs", {x_valid, ram_en, ram_we, rsp_valid, busy}, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_x_q", x_q.size(), 0);
        @(negedge clk); reset_n = 1'b1;
        exp_err = 0;
        send(16'h8001, 1'b0);
        ram_q.push_back(mk(4'b0011, 8'd1, 32'h0000_0077));
        send(16'h0077, 1'b0);
        drain("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout got=%0d want=0", 1);
        $fatal(1, "timeout");
    end

endmodule
